// File: rtl/mpi_mem_slave_if.sv
// Slave-side MPI (Q-bus) signal bundle for the 1801VM1 bus.
// Address/data and all strobes keep their active-low wire polarity.
interface mpi_mem_slave_if;
    logic [15:0] ad_n_in;
    logic [15:0] ad_n_out;
    logic        ad_oe;
    logic        sync_n;
    logic        din_n;
    logic        dout_n;
    logic        wtbt_n;
    logic        rply_n;
    logic        sel;

    modport master (output ad_n_in, sync_n, din_n, dout_n, wtbt_n,
                    input  ad_n_out, ad_oe, rply_n, sel);
    modport slave  (input  ad_n_in, sync_n, din_n, dout_n, wtbt_n,
                    output ad_n_out, ad_oe, rply_n, sel);
endinterface

// File: rtl/mpi_mem_slave.sv
// MPI bus RAM target answering DATI/DATO/DATOB/DATIO with optional wait states.
// Define MPI_MEM_SLAVE_BOOTREG_EN to add the read-only boot register at 177716.
module mpi_mem_slave #(
    parameter logic [15:0] BASE        = 16'o000000,
    parameter int          AW          = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] START_ADDR  = 16'o001000
) (
    input  logic           clk,
    input  logic           rst_n,
    mpi_mem_slave_if.slave bus
);
    typedef enum logic [2:0] {IDLE, MISS, ADDR, RD, RD_HOLD, WR, WR_HOLD} state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t        state, state_nx;
    logic          sync_n_p0, sync_n_p1, sync_n_p2;
    logic          din_n_p0, din_n_p1, din_n_p2;
    logic          dout_n_p0, dout_n_p1, dout_n_p2;
    logic          sync_fall, sync_rise, din_fall, din_rise, dout_fall, dout_rise;
    logic [15:0]   addr_in;
    logic          hit_in, boot_hit_in;
    logic [AW:0]   addr_q;
    logic          boot_q, byte_q, sel_q;
    logic [15:0]   wdata_q, rdata_q;
    logic [3:0]    cnt_q;
    logic          cnt_done;
    logic          rply_act, oe_act;
    logic [15:0]   mem [2**AW];

    // Two-flop synchronizers; the _p2 flop holds the previous synchronized value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sync_n_p0, sync_n_p1, sync_n_p2} <= 3'b111;
            {din_n_p0,  din_n_p1,  din_n_p2}  <= 3'b111;
            {dout_n_p0, dout_n_p1, dout_n_p2} <= 3'b111;
        end else begin
            {sync_n_p0, sync_n_p1, sync_n_p2} <= {bus.sync_n, sync_n_p0, sync_n_p1};
            {din_n_p0,  din_n_p1,  din_n_p2}  <= {bus.din_n,  din_n_p0,  din_n_p1};
            {dout_n_p0, dout_n_p1, dout_n_p2} <= {bus.dout_n, dout_n_p0, dout_n_p1};
        end
    end

    assign sync_fall = sync_n_p2 & ~sync_n_p1;
    assign sync_rise = ~sync_n_p2 & sync_n_p1;
    assign din_fall  = din_n_p2 & ~din_n_p1;
    assign din_rise  = ~din_n_p2 & din_n_p1;
    assign dout_fall = dout_n_p2 & ~dout_n_p1;
    assign dout_rise = ~dout_n_p2 & dout_n_p1;

    assign addr_in = ~bus.ad_n_in;
    assign hit_in  = (addr_in[15:AW+1] == BASE[15:AW+1]);
`ifdef MPI_MEM_SLAVE_BOOTREG_EN
    localparam logic [15:0] BOOT_ADDR = 16'o177716;
    assign boot_hit_in = (addr_in[15:1] == BOOT_ADDR[15:1]);
`else
    assign boot_hit_in = 1'b0;
`endif
    assign cnt_done = (cnt_q == WS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt_q <= '0;
            sel_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                cnt_q <= '0;
            else if ((state == RD || state == WR) && !cnt_done)
                cnt_q <= cnt_q + 4'd1;
            if (sync_rise)
                sel_q <= 1'b0;
            else if (state == IDLE && sync_fall)
                sel_q <= hit_in | boot_hit_in;
        end
    end

    // Reply and driver enable are decoded from state and cut the same cycle a release is seen
    always_comb begin
        state_nx = state;
        rply_act = 1'b0;
        oe_act   = 1'b0;
        case (state)
            IDLE:    if (sync_fall) state_nx = (hit_in || boot_hit_in) ? ADDR : MISS;
            MISS:    state_nx = MISS;
            ADDR: begin
                if (din_fall)       state_nx = RD;
                else if (dout_fall) state_nx = WR;
            end
            RD: begin
                oe_act = 1'b1;
                if (cnt_done) begin
                    rply_act = 1'b1;
                    state_nx = RD_HOLD;
                end
            end
            RD_HOLD: begin
                oe_act   = 1'b1;
                rply_act = 1'b1;
                if (din_rise) begin
                    oe_act   = 1'b0;
                    rply_act = 1'b0;
                    state_nx = ADDR;
                end
            end
            WR: begin
                if (cnt_done) begin
                    rply_act = 1'b1;
                    state_nx = WR_HOLD;
                end
            end
            WR_HOLD: begin
                rply_act = 1'b1;
                if (dout_rise) begin
                    rply_act = 1'b0;
                    state_nx = ADDR;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (sync_rise) begin
            state_nx = IDLE;
            rply_act = 1'b0;
            oe_act   = 1'b0;
        end
    end

    // Datapath: address/data latches and the RAM, never reset
    always_ff @(posedge clk) begin
        if (state == IDLE && sync_fall) begin
            addr_q <= addr_in[AW:0];
            boot_q <= boot_hit_in & ~hit_in;
        end
        if (state == ADDR && din_fall)
            rdata_q <= boot_q ? START_ADDR : mem[addr_q[AW:1]];
        if (state == ADDR && !din_fall && dout_fall) begin
            wdata_q <= addr_in;
            byte_q  <= ~bus.wtbt_n;
        end
        if (state == WR && cnt_q == 4'd0 && !boot_q) begin
            if (!byte_q || !addr_q[0]) mem[addr_q[AW:1]][7:0]  <= wdata_q[7:0];
            if (!byte_q ||  addr_q[0]) mem[addr_q[AW:1]][15:8] <= wdata_q[15:8];
        end
    end

    assign bus.rply_n   = ~rply_act;
    assign bus.ad_oe    = oe_act;
    assign bus.ad_n_out = oe_act ? ~rdata_q : 16'hFFFF;
    assign bus.sel      = sel_q & ~sync_rise;
endmodule

// File: doc/mpi_mem_slave.md
Name: mpi_mem_slave

Overview:
- Synthesizable MPI (Q-bus style) target for the 1801VM1 bus; the responder end of the CPU's SYNC/DIN/DOUT/RPLY handshake.
- Decodes a latched address, serves word/byte reads and writes from internal RAM, and answers DATI, DATO, DATOB and DATIO (read-modify-write) cycles.
- Replaces ad-hoc testbench responders; also used as boot ROM/RAM in FPGA builds.

Parameters:
- BASE, 16'o000000, word-aligned base address of the RAM window.
- AW, 10, RAM word-address width; window size is 2^AW words (2^(AW+1) bytes).
- WAIT_STATES, 0, extra clk cycles before RPLY is asserted (range 0..15).
- START_ADDR, 16'o001000, value returned by the boot register (optional feature).

Ports:
- clk  in  1  system clock, the same as the CPU pin_clk.
- rst_n  in  1  asynchronous active-low reset.
- ad_n_in  in  16  multiplexed address/data bus as seen on the wire (active-low).
- ad_n_out  out  16  data to drive onto the bus (active-low); valid only while ad_oe=1.
- ad_oe  out  1  bus driver enable for ad_n_out.
- sync_n  in  1  address strobe, active-low.
- din_n  in  1  read strobe, active-low.
- dout_n  in  1  write strobe, active-low.
- wtbt_n  in  1  byte-write qualifier; sampled at the DOUT falling edge.
- rply_n  out  1  reply, active-low; the pad is open-drain, so the top level drives 0 only when rply_n=0.
- sel  out  1  high while the latched address hits this slave (debug/arbitration).

Behaviour:
- Reset values: ad_oe=0, ad_n_out=16'hFFFF, rply_n=1, sel=0, FSM=IDLE. RAM contents are not reset.
- Synchronization:
  - sync_n, din_n and dout_n each pass through a 2-flop synchronizer.
  - "Edge" below means a change in the synchronized value.
  - ad_n_in and wtbt_n are sampled directly; the bus guarantees they are stable before the strobes.
- IDLE:
  - On a sync falling edge, latch addr=~ad_n_in.
  - hit = (addr[15:AW+1]==BASE[15:AW+1]).
  - sel=hit. Go to ADDR if hit, otherwise go to MISS.
- MISS: never drive the bus or reply. Return to IDLE on a sync rising edge.
- ADDR:
  - din falling edge: issue RAM read of addr[AW:1] and go to RD.
  - dout falling edge: capture wdata=~ad_n_in and byte=~wtbt_n, then go to WR.
  - If din and dout fall in the same cycle, din wins.
- RD:
  - Cycle 1: the RAM read completes. ad_n_out=~rdata and ad_oe=1.
  - Then count WAIT_STATES cycles, then set rply_n=0 and go to RD_HOLD.
  - Minimum latency: rply_n goes low 1 clk after the synchronized din edge (WAIT_STATES=0).
- RD_HOLD:
  - On a din rising edge: rply_n=1 and ad_oe=0 in the same cycle, then go to ADDR.
  - Returning to ADDR allows the DATO phase of a DATIO cycle under the same SYNC.
- WR:
  - Write the RAM immediately.
  - Word write: both bytes written; addr[0] is ignored.
  - Byte write: addr[0]=0 writes the low byte from wdata[7:0]; addr[0]=1 writes the high byte from wdata[15:8].
  - Then count WAIT_STATES cycles, set rply_n=0 and go to WR_HOLD.
- WR_HOLD: on a dout rising edge, set rply_n=1 and go to ADDR.
- Abort: a sync rising edge in any state immediately forces rply_n=1, ad_oe=0 and sel=0, and returns to IDLE. This includes aborting mid-wait-count. A write already issued in WR is kept.
- Address wrap: the window is decoded exactly, with no aliasing. Addresses outside the window are never answered (the CPU bus timeout applies).
- Reset asserted mid-cycle: all outputs return to reset values asynchronously.
- Reads of never-written words return X in simulation.

Optional Feature:
- Macro MPI_MEM_SLAVE_BOOTREG_EN.
- When defined, address 16'o177716 is an additional hit. DIN returns START_ADDR with normal RD timing. DOUT is acknowledged with RPLY and the data is discarded.
- When undefined, 177716 is decoded only if it falls inside the RAM window; otherwise it follows MISS behaviour.

Test Plan:
1. Reset: hold rst_n=0 for 10 clk -> ad_oe=0, rply_n=1, ad_n_out=16'hFFFF; with sync_n toggling during reset, no reply.
2. Word write then read, BASE=0, WAIT_STATES=0:
   - DATO at 16'o000512 with data 16'o000147 -> rply_n low 1 clk after the synchronized dout edge, high after dout_n rises.
   - DATI at the same address -> bus reads 16'o000147, ad_oe drops in the same cycle that din release is seen.
3. Byte write: word 16'o001000 holds 16'h1234; DATOB at 16'o001001 with data 16'hAB00 -> a following DATI returns 16'hAB34.
4. DATIO at 16'o000100:
   - Read returns the old value 16'h0005.
   - Write 16'h0006 under the same SYNC gets a second RPLY.
   - A later read returns 16'h0006.
5. Miss and abort:
   - DATI at 16'o170000 (outside the window) -> rply_n stays 1 and ad_oe stays 0.
   - With WAIT_STATES=8, raise sync_n 3 clk into RD -> rply_n never asserts and ad_oe=0 within 3 clk.
6. With MPI_MEM_SLAVE_BOOTREG_EN and START_ADDR=16'd512, DATI at 16'o177716 returns 16'd512 (wire value ~512). Without the macro -> no RPLY.
